// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    // Opcode field lives in instruction[31:29].
    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_SW  = 3'b001;
    localparam logic [2:0] OP_BEQ = 3'b010;
    localparam logic [2:0] OP_BLT = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_AND = 3'b110;
    localparam logic [2:0] OP_OR  = 3'b111;

    localparam int DEFAULT_ADDR_W = 16;
    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_DEPTH  = 256;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus: instruction memory read port, ir handshake to decode, and
// branch redirect from execute. master = fetch unit.
interface instruction_fetch_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] inst_address;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] ir;
    logic [ADDR_W-1:0] ir_pc;
    logic              ir_valid;
    logic              ir_ready;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;

    modport master (
        output inst_address, ir, ir_pc, ir_valid,
        input  read_data, ir_ready, redirect_valid, redirect_addr
    );

    modport slave (
        input  inst_address, ir, ir_pc, ir_valid,
        output read_data, ir_ready, redirect_valid, redirect_addr
    );
endinterface

// File: rtl/instruction_fetch_unit_pc_reg.sv
// Program counter with load/increment/hold plus range compares against DEPTH.
module fetch_pc_reg #(
    parameter int ADDR_W   = 16,
    parameter int DEPTH    = 256,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc,
    output logic              in_range,
    output logic              load_ok
);
    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    pc <= ADDR_W'(RESET_PC);
        else if (load) pc <= load_addr;
        else if (inc)  pc <= pc + 1'b1;
    end

    assign in_range = {1'b0, pc} < LIMIT;
    assign load_ok  = {1'b0, load_addr} < LIMIT;
endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC ownership, ir holding register with valid/ready, redirects
// and end-of-program halt. FETCH_PERF_CNT_EN adds fetch/stall/flush counters.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int RESET_PC = 0
) (
    input  logic clk,
    input  logic rst_n,
    instruction_fetch_unit_if.master bus,
    output logic halted,
    output logic fault
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count,
    output logic [15:0] flush_count
`endif
);
    fetch_state_t      state, state_n;
    logic [ADDR_W-1:0] pc;
    logic              pc_in_range, load_ok;
    logic              pc_load, pc_inc, ir_load, fault_set;
    logic [DATA_W-1:0] ir;
    logic [ADDR_W-1:0] ir_pc;

    fetch_pc_reg #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) u_pc (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (pc_load),
        .load_addr (bus.redirect_addr),
        .inc       (pc_inc),
        .pc        (pc),
        .in_range  (pc_in_range),
        .load_ok   (load_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            fault <= 1'b0;
            ir    <= '0;
            ir_pc <= '0;
        end else begin
            state <= state_n;
            if (fault_set) fault <= 1'b1;
            if (ir_load) begin
                ir    <= bus.read_data;
                ir_pc <= pc;
            end
        end
    end

    // Redirect wins over any handshake; a concurrent ir_ready still counts as
    // accepted, but the held ir is dropped rather than replaced.
    always_comb begin
        state_n   = state;
        pc_load   = 1'b0;
        pc_inc    = 1'b0;
        ir_load   = 1'b0;
        fault_set = 1'b0;
        case (state)
            EMPTY, FULL: begin
                if (bus.redirect_valid) begin
                    if (load_ok) begin
                        pc_load = 1'b1;
                        state_n = EMPTY;
                    end else begin
                        fault_set = 1'b1;
                        state_n   = HALT;
                    end
                end else if (state == EMPTY || bus.ir_ready) begin
                    if (pc_in_range) begin
                        ir_load = 1'b1;
                        pc_inc  = 1'b1;
                        state_n = FULL;
                    end else begin
                        state_n = HALT;
                    end
                end
            end
            default: state_n = HALT;
        endcase
    end

    assign bus.inst_address = pc;
    assign bus.ir           = ir;
    assign bus.ir_pc        = ir_pc;
    assign bus.ir_valid     = (state == FULL);
    assign halted           = (state == HALT);

`ifdef FETCH_PERF_CNT_EN
    logic stall_ev, flush_ev;
    assign stall_ev = (state == FULL) && !bus.ir_ready;
    assign flush_ev = (state == FULL) && bus.redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else if (state != HALT) begin
            if (ir_load && fetch_count != '1) fetch_count <= fetch_count + 1'b1;
            if (stall_ev && stall_count != '1) stall_count <= stall_count + 1'b1;
            if (flush_ev && flush_count != '1) flush_count <= flush_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit against a spec-level fetch model.
module tb_instruction_fetch_unit;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic halted, fault;
    logic [31:0] mem [DEPTH];
    int checks = 0;
    int failures = 0;

    // Behavioural model: next pc, whether an instruction is held and where from.
    int  m_pc, m_ir_pc, m_fetch, m_stall, m_flush;
    bit  m_have, m_halt, m_fault;

    instruction_fetch_unit_if #(.ADDR_W(16), .DATA_W(32)) bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count, stall_count;
    logic [15:0] flush_count;
`endif

    instruction_fetch_unit #(.ADDR_W(16), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(0)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus.master),
        .halted (halted),
        .fault  (fault)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count (fetch_count),
        .stall_count (stall_count),
        .flush_count (flush_count)
`endif
    );

    always #5 clk = ~clk;

    assign bus.read_data = (bus.inst_address < 16'(DEPTH)) ? mem[bus.inst_address[7:0]] : 32'h0;

    task automatic model_reset();
        m_pc = 0; m_ir_pc = 0; m_have = 0; m_halt = 0; m_fault = 0;
        m_fetch = 0; m_stall = 0; m_flush = 0;
    endtask

    // Advance model by one clock using the inputs currently driven, then clock the DUT.
    task automatic step();
        if (!m_halt) begin
            if (m_have && !bus.ir_ready) m_stall++;
            if (bus.redirect_valid) begin
                if (m_have) m_flush++;
                m_have = 0;
                if (int'(bus.redirect_addr) >= DEPTH) begin
                    m_halt = 1; m_fault = 1;
                end else begin
                    m_pc = int'(bus.redirect_addr);
                end
            end else if (!m_have || bus.ir_ready) begin
                if (m_pc < DEPTH) begin
                    m_ir_pc = m_pc; m_pc++; m_have = 1; m_fetch++;
                end else begin
                    m_have = 0; m_halt = 1;
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic drive(input bit rdy, input bit rv, input int addr);
        bus.ir_ready = rdy;
        bus.redirect_valid = rv;
        bus.redirect_addr = 16'(addr);
    endtask

    task automatic test_reset();
        drive(1, 0, 0);
        rst_n = 0; model_reset();
        #1;
        checks += 5;
        if (bus.ir_valid !== 1'b0) begin failures++; $display("FAIL reset_ir_valid got=%b want=0", bus.ir_valid); end
        if (bus.ir !== 32'h0) begin failures++; $display("FAIL reset_ir got=%h want=0", bus.ir); end
        if (bus.inst_address !== 16'h0) begin failures++; $display("FAIL reset_pc got=%h want=0", bus.inst_address); end
        if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b want=0", halted); end
        if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b want=0", fault); end
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_ir [3];
        exp_ir[0] = 32'h2000_0004; exp_ir[1] = 32'h0000_0008; exp_ir[2] = 32'h8000_8000;
        drive(1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            checks += 3;
            if (bus.ir_valid !== 1'b1) begin failures++; $display("FAIL seq_valid[%0d] got=%b want=1", i, bus.ir_valid); end
            if (bus.ir !== exp_ir[i]) begin failures++; $display("FAIL seq_ir[%0d] got=%h want=%h", i, bus.ir, exp_ir[i]); end
            if (bus.ir_pc !== 16'(i)) begin failures++; $display("FAIL seq_ir_pc[%0d] got=%0d want=%0d", i, bus.ir_pc, i); end
        end
    endtask

    task automatic test_stall();
        drive(1, 0, 0);
        step();
        drive(0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            checks += 4;
            if (bus.ir_valid !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d] got=%b want=1", i, bus.ir_valid); end
            if (bus.ir !== 32'h4108_0005) begin failures++; $display("FAIL stall_ir[%0d] got=%h want=41080005", i, bus.ir); end
            if (bus.ir_pc !== 16'd3) begin failures++; $display("FAIL stall_ir_pc[%0d] got=%0d want=3", i, bus.ir_pc); end
            if (bus.inst_address !== 16'd4) begin failures++; $display("FAIL stall_addr[%0d] got=%0d want=4", i, bus.inst_address); end
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (stall_count !== 32'd3) begin failures++; $display("FAIL stall_count got=%0d want=3", stall_count); end
`endif
    endtask

    task automatic test_redirect();
        drive(1, 0, 0);
        step();
        drive(0, 1, 5);
        step();
        checks += 2;
        if (bus.ir_valid !== 1'b0) begin failures++; $display("FAIL redir_flush_valid got=%b want=0", bus.ir_valid); end
        if (bus.inst_address !== 16'd5) begin failures++; $display("FAIL redir_pc got=%0d want=5", bus.inst_address); end
        drive(0, 0, 0);
        step();
        checks += 3;
        if (bus.ir_valid !== 1'b1) begin failures++; $display("FAIL redir_valid got=%b want=1", bus.ir_valid); end
        if (bus.ir !== 32'h4120_0008) begin failures++; $display("FAIL redir_ir got=%h want=41200008", bus.ir); end
        if (bus.ir_pc !== 16'd5) begin failures++; $display("FAIL redir_ir_pc got=%0d want=5", bus.ir_pc); end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (flush_count !== 16'd1) begin failures++; $display("FAIL flush_count got=%0d want=1", flush_count); end
`endif
    endtask

    task automatic test_redirect_accept();
        drive(1, 1, 3);
        step();
        checks++;
        if (bus.ir_valid !== 1'b0) begin failures++; $display("FAIL racc_drop got=%b want=0", bus.ir_valid); end
        drive(1, 0, 0);
        step();
        checks += 2;
        if (bus.ir !== 32'h4108_0005) begin failures++; $display("FAIL racc_ir got=%h want=41080005", bus.ir); end
        if (bus.ir_pc !== 16'd3) begin failures++; $display("FAIL racc_ir_pc got=%0d want=3", bus.ir_pc); end
        step();
        checks++;
        if (bus.ir_pc !== 16'd4) begin failures++; $display("FAIL racc_next got=%0d want=4", bus.ir_pc); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0), int'($urandom_range(0, DEPTH-1)));
            step();
            checks += 3;
            if (bus.ir_valid !== m_have) begin failures++; $display("FAIL rnd_valid c=%0d got=%b want=%b", c, bus.ir_valid, m_have); end
            if (bus.inst_address !== 16'(m_pc)) begin failures++; $display("FAIL rnd_addr c=%0d got=%0d want=%0d", c, bus.inst_address, m_pc); end
            if (halted !== m_halt) begin failures++; $display("FAIL rnd_halted c=%0d got=%b want=%b", c, halted, m_halt); end
            if (m_have) begin
                checks += 2;
                if (bus.ir_pc !== 16'(m_ir_pc)) begin failures++; $display("FAIL rnd_ir_pc c=%0d got=%0d want=%0d", c, bus.ir_pc, m_ir_pc); end
                if (bus.ir !== mem[m_ir_pc]) begin failures++; $display("FAIL rnd_ir c=%0d got=%h want=%h", c, bus.ir, mem[m_ir_pc]); end
            end
        end
`ifdef FETCH_PERF_CNT_EN
        checks += 3;
        if (fetch_count !== 32'(m_fetch)) begin failures++; $display("FAIL rnd_fetch_count got=%0d want=%0d", fetch_count, m_fetch); end
        if (stall_count !== 32'(m_stall)) begin failures++; $display("FAIL rnd_stall_count got=%0d want=%0d", stall_count, m_stall); end
        if (flush_count !== 16'(m_flush)) begin failures++; $display("FAIL rnd_flush_count got=%0d want=%0d", flush_count, m_flush); end
`endif
    endtask

    task automatic test_end_of_program();
        bit saw_last = 0;
        int k;
        drive(1, 1, 250);
        step();
        drive(1, 0, 0);
        for (k = 0; k < 20 && !halted; k++) begin
            if (bus.ir_valid && bus.ir_pc == 16'd255) saw_last = 1;
            step();
        end
        checks += 6;
        if (halted !== 1'b1) begin failures++; $display("FAIL end_timeout halted=%b want=1", halted); end
        if (!saw_last) begin failures++; $display("FAIL end_last_seen got=0 want=1"); end
        if (fault !== 1'b0) begin failures++; $display("FAIL end_fault got=%b want=0", fault); end
        if (bus.ir_valid !== 1'b0) begin failures++; $display("FAIL end_valid got=%b want=0", bus.ir_valid); end
        if (bus.inst_address !== 16'd256) begin failures++; $display("FAIL end_addr got=%0d want=256", bus.inst_address); end
        drive(1, 1, 7);
        step(); step();
        if (bus.inst_address !== 16'd256) begin failures++; $display("FAIL end_frozen got=%0d want=256", bus.inst_address); end
    endtask

    task automatic test_fault_and_reset();
        rst_n = 0; model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        drive(1, 0, 0);
        step(); step();
        drive(1, 1, 16'h0100);
        step();
        checks += 3;
        if (halted !== 1'b1) begin failures++; $display("FAIL flt_halted got=%b want=1", halted); end
        if (fault !== 1'b1) begin failures++; $display("FAIL flt_fault got=%b want=1", fault); end
        if (bus.ir_valid !== 1'b0) begin failures++; $display("FAIL flt_valid got=%b want=0", bus.ir_valid); end
        drive(1, 1, 5);
        step();
        checks += 3;
        if (halted !== 1'b1) begin failures++; $display("FAIL flt_ignore_halted got=%b want=1", halted); end
        if (bus.inst_address !== 16'(m_pc)) begin failures++; $display("FAIL flt_ignore_addr got=%0d want=%0d", bus.inst_address, m_pc); end
        if (bus.ir_valid !== 1'b0) begin failures++; $display("FAIL flt_ignore_valid got=%b want=0", bus.ir_valid); end
        // Restart, run a little, then pull reset asynchronously mid-cycle.
        rst_n = 0; model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        drive(1, 0, 0);
        step(); step(); step();
        #2 rst_n = 0; model_reset();
        #1;
        checks += 3;
        if (bus.ir_valid !== 1'b0) begin failures++; $display("FAIL async_valid got=%b want=0", bus.ir_valid); end
        if (bus.inst_address !== 16'd0) begin failures++; $display("FAIL async_pc got=%0d want=0", bus.inst_address); end
        if (fault !== 1'b0) begin failures++; $display("FAIL async_fault got=%b want=0", fault); end
        @(negedge clk);
        rst_n = 1;
        step();
        checks += 2;
        if (bus.ir_pc !== 16'd0) begin failures++; $display("FAIL restart_ir_pc got=%0d want=0", bus.ir_pc); end
        if (bus.ir !== 32'h2000_0004) begin failures++; $display("FAIL restart_ir got=%h want=20000004", bus.ir); end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[0] = 32'h2000_0004; mem[1] = 32'h0000_0008; mem[2] = 32'h8000_8000;
        mem[3] = 32'h4108_0005; mem[4] = 32'h8421_0003; mem[5] = 32'h4120_0008;
        bus.ir_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr = '0;
        #2;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_redirect_accept();
        test_random();
        test_end_of_program();
        test_fault_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
